// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, defaults,
// the fetch buffer layout and the jump-target helper.
package instr_fetch_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          MAX_WAIT_DEFAULT = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_buf_t;

    // J-type target keeps the top nibble of the sequential PC.
    function automatic logic [31:0] jumpTarget(input logic [3:0]  region,
                                               input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the imem handshake, decode handshake and status signals of the fetch unit.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] Instr;
    logic [31:0] PC_out;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic [31:0] Immediate;

    logic [31:0] instr_count;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, Instr, PC_out, PCPlus4, instr_valid,
               instr_count, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump, Immediate
    );

    modport slave (
        input  imem_req, imem_addr, Instr, PC_out, PCPlus4, instr_valid,
               instr_count, fetch_err,
        output imem_ack, imem_rdata, instr_ready, Branch, Zero, Jump, Immediate
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] jumpIndex_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    input  logic [31:0] immediate_i,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] nextPc_o
);

    logic [31:0] branchTarget;

    assign pcPlus4_o    = pc_i + 32'd4;
    assign branchTarget = pcPlus4_o + (immediate_i << 2);

    always_comb begin
        nextPc_o = pcPlus4_o;
        if (jump_i) begin
            nextPc_o = jumpTarget(pcPlus4_o[31:28], jumpIndex_i);
        end else if (branch_i && zero_i) begin
            nextPc_o = branchTarget;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/ack
// and holds it in a single-entry buffer until decode accepts it.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset_L,
    instr_fetch_unit_if.master bus
);

    localparam int              WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    fetch_buf_t        buf_q, buf_d;
    logic [31:0]       instrCount_q, instrCount_d;
    logic              fetchErr_q, fetchErr_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

    logic [31:0] pcPlus4;
    logic [31:0] nextPc;

    next_pc_calc u_next_pc_calc (
        .pc_i        (buf_q.pc),
        .jumpIndex_i (buf_q.instr[25:0]),
        .branch_i    (bus.Branch),
        .zero_i      (bus.Zero),
        .jump_i      (bus.Jump),
        .immediate_i (bus.Immediate),
        .pcPlus4_o   (pcPlus4),
        .nextPc_o    (nextPc)
    );

    // An ack in the last allowed wait cycle still completes the fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        instrCount_d = instrCount_q;
        fetchErr_d   = fetchErr_q;
        waitCnt_d    = waitCnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.imem_ack) begin
                    buf_d.instr = bus.imem_rdata;
                    buf_d.pc    = pc_q;
                    waitCnt_d   = '0;
                    state_d     = ST_FULL;
                end else if (waitCnt_q == WAIT_LAST) begin
                    fetchErr_d = 1'b1;
                    state_d    = ST_ERR;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            ST_FULL: begin
                if (bus.instr_ready) begin
                    pc_d         = nextPc;
                    instrCount_d = instrCount_q + 32'd1;
                    state_d      = ST_REQ;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            instrCount_q <= '0;
            fetchErr_q   <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            instrCount_q <= instrCount_d;
            fetchErr_q   <= fetchErr_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    assign bus.imem_req    = (state_q == ST_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.Instr       = buf_q.instr;
    assign bus.PC_out      = buf_q.pc;
    assign bus.PCPlus4     = pcPlus4;
    assign bus.instr_valid = (state_q == ST_FULL);
    assign bus.instr_count = instrCount_q;
    assign bus.fetch_err   = fetchErr_q;

endmodule
